ahbl_io_bank: RTL and testbench
===============================

AHBL_IO_BANK -- requirements
Module: ahbl_io_bank

Interface
REQ-001 The block SHALL have parameter NUM_OUT, default 4, giving the number of 32-bit output registers (legal 1..16).
REQ-002 The block SHALL have parameter NUM_IN, default 2, giving the number of 32-bit input words (legal 1..16).
REQ-003 The block SHALL have parameter RESET_VAL, default 32'h0000_0000, giving the reset value of every output register.
REQ-004 The block SHALL have these ports:
- HCLK  in  1  sole clock, rising edge.
- HRESET  in  1  reset; one clock, asynchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only [11:0] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 is NONSEQ/SEQ.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1=ERROR.
- out_regs  out  NUM_OUT*32  output registers; reg k at [32k+31:32k].
- in_pins  in  NUM_IN*32  asynchronous inputs; word k at [32k+31:32k].

Function
REQ-005 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; accepted HADDR[11:0], HWRITE and HSIZE SHALL be registered for the data phase.
REQ-006 Decode:
- HADDR[11:10]=00: OUT region, index HADDR[7:2], write mode HADDR[9:8].
- 01: IN region, index HADDR[7:2], read-only.
- 10: ID, word 0 only.
- 11: unmapped.
REQ-007 Byte enables:
- HSIZE=0: lane HADDR[1:0].
- HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
- HSIZE=2: all four lanes.
REQ-008 The transfer SHALL be errored if any of these hold:
- HSIZE>2;
- HSIZE=1 with HADDR[0]=1;
- HSIZE=2 with HADDR[1:0]!=0;
- region 11;
- OUT index >= NUM_OUT;
- IN index >= NUM_IN;
- ID with HADDR[9:2]!=0;
- any write to IN or ID.
REQ-009 OUT write modes SHALL act on the enabled lanes only, with D = HWDATA:
- 00 write: R=D.
- 01 set: R|=D.
- 10 clear: R&=~D.
- 11 toggle: R^=D.
Disabled lanes SHALL be unchanged.
REQ-010 An OK write SHALL take effect at the rising edge ending its data phase (zero wait states); out_regs SHALL show the new value from that edge.
REQ-011 Reads SHALL complete with zero wait states. During the read data phase HRDATA SHALL be:
- OUT region: the register's current value, mode bits ignored.
- IN region: the synchronised word.
- ID: {8'hA5, 8'h01, NUM_IN[7:0], NUM_OUT[7:0]}.
REQ-012 Outside read data phases, and during errors, HRDATA SHALL be 0.
REQ-013 Each in_pins bit SHALL pass a two-flop synchroniser; a stable change SHALL be readable at the latest in a read whose data phase starts 3 HCLK edges after the change.
REQ-014 Response state machine:
- OKAY: HREADYOUT=1, HRESP=0. An errored accepted transfer goes to ERR1.
- ERR1: HREADYOUT=0, HRESP=1; goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1; goes to ERR1 if another errored transfer is accepted that cycle, else OKAY.
REQ-015 An errored transfer SHALL NOT modify any register.
REQ-016 Back-to-back write then read of the same register SHALL return the newly written value.
REQ-017 When HREADY is low (another slave stalling), no address phase SHALL be accepted and the registered phase SHALL be held.
REQ-018 IDLE/BUSY transfers and HSEL=0 SHALL produce an OKAY zero-wait response with no state change.

Reset
REQ-019 While HRESET=1, asynchronously:
- every out_regs word = RESET_VAL;
- synchroniser flops = 0;
- registered phase cleared, state = OKAY;
- HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-020 Reset asserted during a data phase SHALL abort the transfer with no register update; operation SHALL resume at the first edge after HRESET falls.

Verification
REQ-021 Word write 0x12345678 to OUT0, then byte write 0xAB at 0x002 -> out_regs[31:0]=0x12AB5678; read returns same.
REQ-022 OUT1=0x0000FFFF; set-mode write 0xFF000000 at 0x104 -> 0xFF00FFFF; clear 0x0000000F at 0x204 -> 0xFF00FFF0; toggle 0xFFFFFFFF at 0x304 -> 0x00FF000F.
REQ-023 Write to 0x400 (IN0), or word access at 0x006 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; all registers unchanged.
REQ-024 in_pins word0 = 0xDEADBEEF held; read 0x400 three edges later -> HRDATA=0xDEADBEEF. Read 0x800 with defaults -> 0xA5010204.
REQ-025 Assert HRESET mid write data phase -> out_regs = RESET_VAL, HREADYOUT=1, HRESP=0; the next transfer after release completes normally.

Source files
------------

// File: rtl/ahbl_io_bank.sv
// rtl/ahbl_io_bank.sv - AHB-Lite slave with modifiable output registers, synchronised input words and an ID word
module ahbl_io_bank #(
  parameter int          NUM_OUT   = 4,
  parameter int          NUM_IN    = 2,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_OUT*32-1:0] out_regs,
  input  logic [NUM_IN*32-1:0]  in_pins
);

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;

  state_t                 state;
  logic [31:0]            regs [NUM_OUT];
  logic [NUM_IN*32-1:0]   sync1, sync2;
  logic                   dp_valid, dp_write;
  logic [11:0]            dp_addr;
  logic [2:0]             dp_size;
  logic                   accept, addr_err;
  logic [3:0]             be;
  logic [31:0]            mask, cur, mod_val, wr_val, rdata;
  logic                   unused_addr;

  assign unused_addr = ^HADDR[31:12];
  assign accept      = HSEL & HREADY & HTRANS[1];

  // Errors are decided entirely from the address phase, so the data phase only carries OK transfers.
  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2) addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0]) addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) addr_err = 1'b1;
    case (HADDR[11:10])
      2'b00:   if (int'({26'd0, HADDR[7:2]}) >= NUM_OUT) addr_err = 1'b1;
      2'b01:   if (int'({26'd0, HADDR[7:2]}) >= NUM_IN || HWRITE) addr_err = 1'b1;
      2'b10:   if (HADDR[9:2] != 8'd0 || HWRITE) addr_err = 1'b1;
      default: addr_err = 1'b1;
    endcase
  end

  always_comb begin
    case (dp_size)
      3'd0:    be = 4'b0001 << dp_addr[1:0];
      3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    cur = 32'd0;
    for (int k = 0; k < NUM_OUT; k++)
      if (dp_addr[7:2] == 6'(k)) cur = regs[k];
    case (dp_addr[9:8])
      2'b00:   mod_val = HWDATA;
      2'b01:   mod_val = cur | HWDATA;
      2'b10:   mod_val = cur & ~HWDATA;
      default: mod_val = cur ^ HWDATA;
    endcase
    wr_val = (cur & ~mask) | (mod_val & mask);
  end

  always_comb begin
    rdata = 32'd0;
    if (dp_valid && !dp_write) begin
      case (dp_addr[11:10])
        2'b00: rdata = cur;
        2'b01: begin
          for (int k = 0; k < NUM_IN; k++)
            if (dp_addr[7:2] == 6'(k)) rdata = sync2[32*k +: 32];
        end
        2'b10:   rdata = {8'hA5, 8'h01, 8'(NUM_IN), 8'(NUM_OUT)};
        default: rdata = 32'd0;
      endcase
    end
  end
  assign HRDATA = rdata;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < NUM_OUT; k++) regs[k] <= RESET_VAL;
      sync1     <= '0;
      sync2     <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_addr   <= 12'd0;
      dp_size   <= 3'd0;
      state     <= S_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      sync1 <= in_pins;
      sync2 <= sync1;
      // A low HREADY freezes the pending data phase and blocks new address phases.
      if (HREADY) begin
        if (dp_valid && dp_write)
          for (int k = 0; k < NUM_OUT; k++)
            if (dp_addr[7:2] == 6'(k)) regs[k] <= wr_val;
        dp_valid <= accept && !addr_err;
        dp_write <= HWRITE;
        dp_addr  <= HADDR[11:0];
        dp_size  <= HSIZE;
      end
      case (state)
        S_OKAY: if (accept && addr_err) begin
          state <= S_ERR1; HREADYOUT <= 1'b0; HRESP <= 1'b1;
        end
        S_ERR1: begin
          state <= S_ERR2; HREADYOUT <= 1'b1; HRESP <= 1'b1;
        end
        default: if (accept && addr_err) begin
          state <= S_ERR1; HREADYOUT <= 1'b0; HRESP <= 1'b1;
        end else begin
          state <= S_OKAY; HREADYOUT <= 1'b1; HRESP <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahbl_io_bank.sv
// tb/tb_ahbl_io_bank.sv - directed bench for ahbl_io_bank with a transaction-level register model
module tb_ahbl_io_bank;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic          HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY;
  logic [31:0]   HADDR = 32'd0, HWDATA = 32'd0, HRDATA;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic          HREADYOUT, HRESP;
  logic [NO*32-1:0] out_regs;
  logic [NI*32-1:0] in_pins;
  logic          stall = 1'b0;

  logic [31:0] model_regs [NO];
  logic [31:0] model_in [NI];
  logic        exp_ready = 1'b1, exp_resp = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  int checks = 0, failures = 0;
  logic [31:0] rd;

  assign HREADY  = stall ? 1'b0 : HREADYOUT;
  assign in_pins = {model_in[1], model_in[0]};

  ahbl_io_bank #(.NUM_OUT(NO), .NUM_IN(NI), .RESET_VAL(RV)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .out_regs(out_regs), .in_pins(in_pins));

  always #5 HCLK = ~HCLK;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endfunction

  function automatic logic model_err(input logic w, input logic [11:0] a, input logic [2:0] sz);
    int idx = int'(a[7:2]);
    logic e = 1'b0;
    if (sz > 3'd2 || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)) e = 1'b1;
    if (a[11:10] == 2'd3) e = 1'b1;
    if (a[11:10] == 2'd0 && idx >= NO) e = 1'b1;
    if (a[11:10] == 2'd1 && (idx >= NI || w)) e = 1'b1;
    if (a[11:10] == 2'd2 && (a[9:2] != 8'd0 || w)) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a[11:10] == 2'd0) return model_regs[a[7:2]];
    if (a[11:10] == 2'd1) return model_in[a[7:2]];
    return 32'hA501_0000 | (NI << 8) | NO;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d);
    logic [7:0] r, x;
    bit en;
    for (int b = 0; b < 4; b++) begin
      en = (sz == 3'd0) ? (b == int'(a[1:0])) : (sz == 3'd1) ? ((b / 2) == int'(a[1])) : 1'b1;
      if (en) begin
        r = model_regs[a[7:2]][8*b +: 8];
        x = d[8*b +: 8];
        case (a[9:8])
          2'd0: r = x;
          2'd1: r = r | x;
          2'd2: r = r & ~x;
          default: r = r ^ x;
        endcase
        model_regs[a[7:2]][8*b +: 8] = r;
      end
    end
  endfunction

  always @(negedge HCLK) begin
    for (int k = 0; k < NO; k++) check("out_regs", out_regs[32*k +: 32], model_regs[k]);
    check("hreadyout", {31'd0, HREADYOUT}, {31'd0, exp_ready});
    check("hresp", {31'd0, HRESP}, {31'd0, exp_resp});
    check("hrdata", HRDATA, exp_rdata);
  end

  task automatic xfer(input logic w, input logic [11:0] a, input logic [2:0] sz,
                      input logic [31:0] d, output logic [31:0] got);
    logic e;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {20'd0, a}; HWRITE = w; HSIZE = sz;
    e = model_err(w, a, sz);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    if (e) begin exp_ready = 1'b0; exp_resp = 1'b1; exp_rdata = 32'd0; end
    else begin exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = w ? 32'd0 : model_read(a); end
    #3 got = HRDATA;
    @(posedge HCLK); #1;
    if (!e && w) model_write(a, sz, d);
    if (e) begin
      exp_ready = 1'b1; exp_resp = 1'b1; exp_rdata = 32'd0;
      @(posedge HCLK); #1;
    end
    exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = 32'd0;
  endtask

  task automatic wr_then_rd(input logic [11:0] a, input logic [31:0] d, output logic [31:0] got);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {20'd0, a}; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HWDATA = d; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    model_write(a, 3'd2, d);
    HSEL = 1'b0; HTRANS = 2'b00;
    exp_rdata = model_read(a);
    #3 got = HRDATA;
    @(posedge HCLK); #1;
    exp_rdata = 32'd0;
  endtask

  task automatic quiet_cycle(input logic sel, input logic [1:0] tr, input logic stl);
    @(posedge HCLK); #1;
    stall = stl; HSEL = sel; HTRANS = tr; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    stall = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFFF;
    @(posedge HCLK); #1;
  endtask

  initial begin
    for (int k = 0; k < NO; k++) model_regs[k] = RV;
    model_in[0] = 32'd0; model_in[1] = 32'd0;
    #22 HRESET = 1'b0;

    xfer(1'b1, 12'h000, 3'd2, 32'h1234_5678, rd);
    xfer(1'b1, 12'h002, 3'd0, 32'h00AB_0000, rd);
    check("lit_out0", out_regs[31:0], 32'h12AB_5678);
    xfer(1'b0, 12'h000, 3'd2, 32'd0, rd);
    check("lit_rd_out0", rd, 32'h12AB_5678);

    xfer(1'b1, 12'h004, 3'd2, 32'h0000_FFFF, rd);
    xfer(1'b1, 12'h104, 3'd2, 32'hFF00_0000, rd);
    check("lit_set", out_regs[63:32], 32'hFF00_FFFF);
    xfer(1'b1, 12'h204, 3'd2, 32'h0000_000F, rd);
    check("lit_clr", out_regs[63:32], 32'hFF00_FFF0);
    xfer(1'b1, 12'h304, 3'd2, 32'hFFFF_FFFF, rd);
    check("lit_tog", out_regs[63:32], 32'h00FF_000F);

    xfer(1'b1, 12'h00E, 3'd1, 32'hBEEF_1234, rd);
    xfer(1'b1, 12'h30C, 3'd1, 32'h5555_FFFF, rd);
    xfer(1'b1, 12'h109, 3'd0, 32'hFFFF_F0FF, rd);
    xfer(1'b0, 12'h00C, 3'd2, 32'd0, rd);
    check("lit_out3", rd, 32'hBEEF_FFFF);

    xfer(1'b1, 12'h400, 3'd2, 32'h1111_1111, rd);
    xfer(1'b0, 12'h006, 3'd2, 32'd0, rd);
    xfer(1'b0, 12'h000, 3'd3, 32'd0, rd);
    xfer(1'b1, 12'h010, 3'd2, 32'hFFFF_FFFF, rd);
    xfer(1'b0, 12'h408, 3'd2, 32'd0, rd);
    xfer(1'b0, 12'h804, 3'd2, 32'd0, rd);
    xfer(1'b0, 12'hC00, 3'd2, 32'd0, rd);
    xfer(1'b1, 12'h001, 3'd1, 32'hFFFF_FFFF, rd);
    xfer(1'b1, 12'h800, 3'd2, 32'hFFFF_FFFF, rd);

    quiet_cycle(1'b1, 2'b10, 1'b1);
    quiet_cycle(1'b1, 2'b00, 1'b0);
    quiet_cycle(1'b1, 2'b01, 1'b0);
    quiet_cycle(1'b0, 2'b10, 1'b0);

    wr_then_rd(12'h008, 32'hCAFE_F00D, rd);
    check("lit_b2b", rd, 32'hCAFE_F00D);

    @(posedge HCLK); #1;
    model_in[0] = 32'hDEAD_BEEF; model_in[1] = 32'h1357_9BDF;
    @(posedge HCLK);
    xfer(1'b0, 12'h400, 3'd2, 32'd0, rd);
    check("lit_in0", rd, 32'hDEAD_BEEF);
    xfer(1'b0, 12'h404, 3'd2, 32'd0, rd);
    check("lit_in1", rd, 32'h1357_9BDF);
    xfer(1'b0, 12'h800, 3'd2, 32'd0, rd);
    check("lit_id", rd, 32'hA501_0204);

    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h008; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h5555_AAAA;
    #1 HRESET = 1'b1;
    for (int k = 0; k < NO; k++) model_regs[k] = RV;
    @(posedge HCLK); #1;
    check("lit_rst_ready", {31'd0, HREADYOUT}, 32'd1);
    check("lit_rst_out", out_regs[95:64], RV);
    HRESET = 1'b0;
    xfer(1'b1, 12'h008, 3'd2, 32'h0BAD_F00D, rd);
    xfer(1'b0, 12'h008, 3'd2, 32'd0, rd);
    check("lit_after_rst", rd, 32'h0BAD_F00D);

    @(posedge HCLK); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
